// File: rtl/char_lane_tracker_pkg.sv
// Shared types and constants for the falling-character lane tracker.
package char_lane_tracker_pkg;
  localparam int NUM_SLOTS_DEF = 8;

  localparam logic [7:0] ASCII_A = 8'd65;
  localparam logic [7:0] ASCII_Z = 8'd90;
  localparam logic [7:0] ASCII_a = 8'd97;

  typedef struct packed {
    logic       valid;
    logic [7:0] ch;
    logic [2:0] speed;
    logic [8:0] x;
    logic [9:0] y;
  } slot_t;

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

  // Map 'a'..'z' onto 'A'..'Z'; everything else passes through.
  function automatic logic [7:0] fold_key(input logic [7:0] k);
    if (k >= ASCII_a && k <= ASCII_Z + 8'd32) return k - (ASCII_a - ASCII_A);
    return k;
  endfunction
endpackage

// File: rtl/char_lane_tracker_free_slot_finder.sv
// Lowest-index free slot priority encoder; found=0 means every slot is live.
module free_slot_finder #(
  parameter int N = 8
) (
  input  logic [N-1:0]         valid,
  output logic [$clog2(N)-1:0] idx,
  output logic                 found
);
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        found = 1'b1;
        idx   = ($clog2(N))'(i);
      end
    end
  end
endmodule

// File: rtl/char_lane_tracker.sv
// Slot pool for falling characters: spawn, per-frame advance, key match scan, stats.
// Build option CASE_FOLD_EN: lowercase keys are folded to uppercase before matching.
module char_lane_tracker
  import char_lane_tracker_pkg::*;
#(
  parameter int         NUM_SLOTS = NUM_SLOTS_DEF,
  parameter logic [8:0] X_LIMIT   = 9'd470,
  parameter int         SCORE_W   = 16,
  localparam int        IDX_W     = $clog2(NUM_SLOTS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               spawn_tick,
  input  logic [7:0]         gen_ch,
  input  logic [2:0]         gen_speed,
  input  logic [8:0]         gen_x,
  input  logic [9:0]         gen_y,
  input  logic               frame_tick,
  input  logic               key_valid,
  input  logic [7:0]         key_code,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic               rd_valid,
  output logic [7:0]         rd_ch,
  output logic [8:0]         rd_x,
  output logic [9:0]         rd_y,
  output logic               busy,
  output logic               full,
  output logic               hit,
  output logic               miss,
  output logic               drop,
  output logic [SCORE_W-1:0] score,
  output logic [7:0]         miss_cnt
);
  slot_t                           slots [NUM_SLOTS];
  state_t                          state_q, state_d;
  logic [7:0]                      key_q, key_in;
  logic [IDX_W-1:0]                idx_q, best_idx, free_idx;
  logic [8:0]                      best_x;
  logic                            best_found, free_found, commit_ok, better;
  logic [NUM_SLOTS-1:0]            vld_vec, clr_vec, ret_vec, spawn_vec;
  logic [NUM_SLOTS-1:0][9:0]       sum_vec;
  logic [4:0]                      ret_cnt;
  logic [8:0]                      miss_sum;
  logic [SCORE_W:0]                score_sum;
  slot_t                           new_slot;

`ifdef CASE_FOLD_EN
  assign key_in = fold_key(key_code);
`else
  assign key_in = key_code;
`endif

  free_slot_finder #(.N(NUM_SLOTS)) u_free (
    .valid (vld_vec),
    .idx   (free_idx),
    .found (free_found)
  );

  assign rd_valid = slots[rd_idx].valid;
  assign rd_ch    = slots[rd_idx].ch;
  assign rd_x     = slots[rd_idx].x;
  assign rd_y     = slots[rd_idx].y;
  assign busy     = (state_q != IDLE);

  assign commit_ok = (state_q == COMMIT) && best_found &&
                     slots[best_idx].valid && (slots[best_idx].ch == key_q);
  assign better    = slots[idx_q].valid && (slots[idx_q].ch == key_q) &&
                     (!best_found || slots[idx_q].x > best_x);
  assign score_sum = {1'b0, score} + (SCORE_W+1)'(slots[best_idx].speed);
  assign miss_sum  = {1'b0, miss_cnt} + 9'(ret_cnt);

  always_comb begin
    new_slot       = '0;
    new_slot.valid = 1'b1;
    new_slot.ch    = gen_ch;
    new_slot.speed = (gen_speed == 3'd0) ? 3'd1 : gen_speed;
    new_slot.x     = gen_x;
    new_slot.y     = gen_y;
  end

  // A commit clear wins over the frame advance, so a slot is never both hit and missed.
  always_comb begin
    vld_vec   = '0;
    ret_vec   = '0;
    sum_vec   = '0;
    ret_cnt   = '0;
    clr_vec   = commit_ok ? (NUM_SLOTS'(1) << best_idx) : '0;
    spawn_vec = (spawn_tick && free_found) ? (NUM_SLOTS'(1) << free_idx) : '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      vld_vec[i] = slots[i].valid;
      sum_vec[i] = {1'b0, slots[i].x} + {7'd0, slots[i].speed};
      ret_vec[i] = frame_tick && slots[i].valid && !clr_vec[i] &&
                   (sum_vec[i] >= {1'b0, X_LIMIT});
      ret_cnt    = ret_cnt + {4'd0, ret_vec[i]};
    end
  end

  // Spawn only targets a free slot, so it never collides with clear or advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) slots[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (clr_vec[i])                          slots[i].valid <= 1'b0;
        else if (frame_tick && slots[i].valid) begin
          if (ret_vec[i])                        slots[i].valid <= 1'b0;
          else                                   slots[i].x     <= sum_vec[i][8:0];
        end else if (spawn_vec[i])               slots[i]       <= new_slot;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full     <= 1'b0;
      hit      <= 1'b0;
      miss     <= 1'b0;
      drop     <= 1'b0;
      score    <= '0;
      miss_cnt <= '0;
    end else begin
      full <= !free_found;
      hit  <= commit_ok;
      miss <= |ret_vec;
      drop <= spawn_tick && !free_found;
      if (commit_ok) score <= score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
      miss_cnt <= miss_sum[8] ? 8'hFF : miss_sum[7:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (key_valid) state_d = SCAN;
      SCAN:    if (idx_q == IDX_W'(NUM_SLOTS - 1)) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Scan walks ascending with strict '>', so equal rows keep the lower index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q      <= '0;
      idx_q      <= '0;
      best_idx   <= '0;
      best_x     <= '0;
      best_found <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (key_valid) begin
          key_q      <= key_in;
          idx_q      <= '0;
          best_found <= 1'b0;
        end
        SCAN: begin
          idx_q <= idx_q + 1'b1;
          if (better) begin
            best_found <= 1'b1;
            best_idx   <= idx_q;
            best_x     <= slots[idx_q].x;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_char_lane_tracker.sv
// Self-checking bench for char_lane_tracker: directed scenarios plus randomized model comparison.
module tb_char_lane_tracker;
  localparam int N    = 8;
  localparam int XLIM = 470;

  logic       clk = 0, rst = 1;
  logic       spawn_tick = 0, frame_tick = 0, key_valid = 0;
  logic [7:0] gen_ch = 0, key_code = 0;
  logic [2:0] gen_speed = 0;
  logic [8:0] gen_x = 0;
  logic [9:0] gen_y = 0;
  logic [2:0] rd_idx = 0;
  logic       rd_valid, busy, full, hit, miss, drop;
  logic [7:0] rd_ch, miss_cnt;
  logic [8:0] rd_x;
  logic [9:0] rd_y;
  logic [15:0] score;

  int checks = 0, errors = 0;

  char_lane_tracker dut (
    .clk(clk), .rst(rst), .spawn_tick(spawn_tick), .gen_ch(gen_ch), .gen_speed(gen_speed),
    .gen_x(gen_x), .gen_y(gen_y), .frame_tick(frame_tick), .key_valid(key_valid),
    .key_code(key_code), .rd_idx(rd_idx), .rd_valid(rd_valid), .rd_ch(rd_ch), .rd_x(rd_x),
    .rd_y(rd_y), .busy(busy), .full(full), .hit(hit), .miss(miss), .drop(drop),
    .score(score), .miss_cnt(miss_cnt)
  );

  always #10 clk = ~clk;

  // Reference model: slot pool as plain arrays, match as a snapshot list evaluated at commit.
  bit         m_v [N];
  int         m_ch [N], m_sp [N], m_x [N], m_y [N];
  bit         snap_c [N];
  int         snap_x [N];
  bit         m_busy, m_hit, m_miss, m_drop, m_full;
  int         m_cnt, m_key, m_score, m_mcnt;

  function automatic int fold(input int k);
`ifdef CASE_FOLD_EN
    if (k >= 97 && k <= 122) return k - 32;
`endif
    return k;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_v[i] = 0; m_ch[i] = 0; m_sp[i] = 0; m_x[i] = 0; m_y[i] = 0;
    end
    m_busy = 0; m_hit = 0; m_miss = 0; m_drop = 0; m_full = 0;
    m_cnt = 0; m_key = 0; m_score = 0; m_mcnt = 0;
  endtask

  task automatic model_step();
    bit pv [N];
    int best, bx, rc, s, fs;
    for (int i = 0; i < N; i++) pv[i] = m_v[i];
    m_hit = 0; m_miss = 0; m_drop = 0;
    if (m_busy) begin
      if (m_cnt <= N) begin
        snap_c[m_cnt-1] = pv[m_cnt-1] && (m_ch[m_cnt-1] == m_key);
        snap_x[m_cnt-1] = m_x[m_cnt-1];
        m_cnt++;
      end else begin
        best = -1; bx = -1;
        for (int j = 0; j < N; j++)
          if (snap_c[j] && snap_x[j] > bx) begin best = j; bx = snap_x[j]; end
        if (best >= 0 && m_v[best] && m_ch[best] == m_key) begin
          m_v[best] = 0; m_hit = 1;
          m_score = (m_score + m_sp[best] > 65535) ? 65535 : m_score + m_sp[best];
        end
        m_busy = 0;
      end
    end else if (key_valid) begin
      m_busy = 1; m_cnt = 1; m_key = fold(int'(key_code));
    end
    if (frame_tick) begin
      rc = 0;
      for (int i = 0; i < N; i++) if (m_v[i]) begin
        s = m_x[i] + m_sp[i];
        if (s >= XLIM) begin m_v[i] = 0; rc++; end
        else m_x[i] = s;
      end
      m_miss = (rc > 0);
      m_mcnt = (m_mcnt + rc > 255) ? 255 : m_mcnt + rc;
    end
    fs = -1;
    for (int i = N - 1; i >= 0; i--) if (!pv[i]) fs = i;
    if (spawn_tick) begin
      if (fs < 0) m_drop = 1;
      else begin
        m_v[fs] = 1; m_ch[fs] = gen_ch; m_sp[fs] = (gen_speed == 0) ? 1 : gen_speed;
        m_x[fs] = gen_x; m_y[fs] = gen_y;
      end
    end
    m_full = (fs < 0);
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk); #1;
    spawn_tick = 0; frame_tick = 0; key_valid = 0;
  endtask

  task automatic do_reset();
    rst = 1; spawn_tick = 0; frame_tick = 0; key_valid = 0;
    @(posedge clk); #1;
    rst = 0;
    model_reset();
  endtask

  task automatic spawn(input int ch, input int sp, input int x, input int y);
    spawn_tick = 1; gen_ch = 8'(ch); gen_speed = 3'(sp); gen_x = 9'(x); gen_y = 10'(y);
    cyc();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if ({busy, full, hit, miss, drop} !== 5'b0) begin
      errors++; $display("FAIL reset_flags got %b want 00000", {busy, full, hit, miss, drop}); end
    checks++; if (score !== 0 || miss_cnt !== 0) begin
      errors++; $display("FAIL reset_counts got score=%0d miss_cnt=%0d want 0/0", score, miss_cnt); end
    for (int i = 0; i < N; i++) begin
      rd_idx = 3'(i); #1;
      checks++; if (rd_valid !== 0 || rd_x !== 0 || rd_ch !== 0 || rd_y !== 0) begin
        errors++; $display("FAIL reset_slot%0d got v=%b x=%0d want 0", i, rd_valid, rd_x); end
    end
  endtask

  task automatic test_spawn_advance();
    do_reset();
    spawn(65, 2, 0, 10);
    rd_idx = 0; #1;
    checks++; if (rd_valid !== 1 || rd_ch !== 65 || rd_y !== 10 || rd_x !== 0) begin
      errors++; $display("FAIL spawn_slot0 got v=%b ch=%0d y=%0d x=%0d want 1/65/10/0",
                         rd_valid, rd_ch, rd_y, rd_x); end
    repeat (3) begin frame_tick = 1; cyc(); end
    #1;
    checks++; if (rd_x !== 6) begin errors++; $display("FAIL advance_x got %0d want 6", rd_x); end
  endtask

  task automatic test_full_drop();
    do_reset();
    for (int i = 0; i < N; i++) spawn(66 + i, 1, i * 10, i);
    spawn(90, 5, 200, 200);
    checks++; if (drop !== 1 || full !== 1) begin
      errors++; $display("FAIL full_drop got drop=%b full=%b want 1/1", drop, full); end
    for (int i = 0; i < N; i++) begin
      rd_idx = 3'(i); #1;
      checks++; if (rd_valid !== 1 || rd_ch !== 8'(66 + i) || rd_x !== 9'(i * 10)) begin
        errors++; $display("FAIL full_slot%0d got v=%b ch=%0d x=%0d want 1/%0d/%0d",
                           i, rd_valid, rd_ch, rd_x, 66 + i, i * 10); end
    end
    cyc();
    checks++; if (drop !== 0) begin errors++; $display("FAIL drop_pulse got %b want 0", drop); end
  endtask

  task automatic test_hit();
    int lat;
    do_reset();
    spawn(65, 1, 40, 0); spawn(66, 1, 0, 0); spawn(67, 1, 0, 0); spawn(65, 5, 100, 0);
    key_valid = 1; key_code = 65; lat = 0;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      if (hit) begin lat = k; break; end
    end
    checks++; if (lat !== N + 2) begin errors++; $display("FAIL hit_latency got %0d want %0d", lat, N + 2); end
    rd_idx = 3; #1;
    checks++; if (rd_valid !== 0) begin errors++; $display("FAIL hit_slot3 got v=%b want 0", rd_valid); end
    rd_idx = 0; #1;
    checks++; if (rd_valid !== 1) begin errors++; $display("FAIL hit_slot0 got v=%b want 1", rd_valid); end
    checks++; if (score !== 5 || busy !== 0) begin
      errors++; $display("FAIL hit_score got score=%0d busy=%b want 5/0", score, busy); end
  endtask

  task automatic test_miss_nohit();
    int drop_at; bit saw_hit;
    do_reset();
    spawn(77, 3, 468, 5);
    frame_tick = 1; cyc();
    rd_idx = 0; #1;
    checks++; if (rd_valid !== 0 || miss !== 1 || miss_cnt !== 1) begin
      errors++; $display("FAIL miss got v=%b miss=%b miss_cnt=%0d want 0/1/1", rd_valid, miss, miss_cnt); end
    cyc();
    checks++; if (miss !== 0) begin errors++; $display("FAIL miss_pulse got %b want 0", miss); end
    spawn(66, 1, 5, 0);
    key_valid = 1; key_code = 81; drop_at = 0; saw_hit = 0;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      if (hit) saw_hit = 1;
      if (!busy && drop_at == 0) drop_at = k;
    end
    checks++; if (drop_at !== N + 2 || saw_hit !== 0) begin
      errors++; $display("FAIL nohit got busy_drop=%0d hit=%b want %0d/0", drop_at, saw_hit, N + 2); end
  endtask

  task automatic test_commit_vs_frame();
    do_reset();
    spawn(66, 1, 0, 0); spawn(67, 1, 0, 0); spawn(90, 7, 465, 0);
    key_valid = 1; key_code = 90; cyc();
    repeat (N) cyc();
    frame_tick = 1; cyc();
    checks++; if (hit !== 1 || miss !== 0 || miss_cnt !== 0) begin
      errors++; $display("FAIL commit_frame got hit=%b miss=%b miss_cnt=%0d want 1/0/0", hit, miss, miss_cnt); end
    rd_idx = 2; #1;
    checks++; if (rd_valid !== 0) begin errors++; $display("FAIL commit_slot2 got v=%b want 0", rd_valid); end
    rd_idx = 0; #1;
    checks++; if (rd_x !== 1 || rd_valid !== 1) begin
      errors++; $display("FAIL commit_adv got v=%b x=%0d want 1/1", rd_valid, rd_x); end
  endtask

  task automatic test_case_fold();
    bit saw_hit, want;
    do_reset();
    spawn(65, 3, 50, 0);
    key_valid = 1; key_code = 97; saw_hit = 0;
    repeat (N + 2) begin cyc(); if (hit) saw_hit = 1; end
`ifdef CASE_FOLD_EN
    want = 1;
`else
    want = 0;
`endif
    rd_idx = 0; #1;
    checks++; if (saw_hit !== want || rd_valid !== !want) begin
      errors++; $display("FAIL case_fold got hit=%b v=%b want %b/%b", saw_hit, rd_valid, want, !want); end
  endtask

  task automatic test_reset_midscan();
    bit saw_hit;
    do_reset();
    spawn(65, 4, 30, 0);
    key_valid = 1; key_code = 65; cyc(); cyc(); cyc();
    rst = 1; #1;
    rd_idx = 0; #1;
    checks++; if ({busy, full, hit, miss, drop, rd_valid} !== 6'b0 || score !== 0 || miss_cnt !== 0) begin
      errors++; $display("FAIL rst_midscan got flags=%b score=%0d miss_cnt=%0d want 0",
                         {busy, full, hit, miss, drop, rd_valid}, score, miss_cnt); end
    rst = 0; model_reset(); saw_hit = 0;
    repeat (N + 4) begin cyc(); if (hit) saw_hit = 1; end
    checks++; if (saw_hit !== 0 || busy !== 0) begin
      errors++; $display("FAIL rst_nohit got hit=%b busy=%b want 0/0", saw_hit, busy); end
  endtask

  task automatic test_random();
    int keys [5] = '{65, 66, 67, 68, 97};
    do_reset();
    for (int c = 0; c < 500; c++) begin
      spawn_tick = ($urandom_range(99) < 35);
      gen_ch     = 8'(65 + $urandom_range(3));
      gen_speed  = 3'($urandom_range(7));
      gen_x      = 9'($urandom_range(480));
      gen_y      = 10'($urandom);
      frame_tick = ($urandom_range(99) < 20);
      key_valid  = ($urandom_range(99) < 15);
      key_code   = 8'(keys[$urandom_range(4)]);
      cyc();
      checks++; if ({hit, miss, drop, full, busy} !== {m_hit, m_miss, m_drop, m_full, m_busy}) begin
        errors++; $display("FAIL rand_flags c=%0d got %b want %b", c,
                           {hit, miss, drop, full, busy}, {m_hit, m_miss, m_drop, m_full, m_busy}); end
      checks++; if (score !== 16'(m_score) || miss_cnt !== 8'(m_mcnt)) begin
        errors++; $display("FAIL rand_counts c=%0d got %0d/%0d want %0d/%0d", c,
                           score, miss_cnt, m_score, m_mcnt); end
      for (int i = 0; i < N; i++) begin
        rd_idx = 3'(i); #1;
        checks++;
        if (rd_valid !== m_v[i] ||
            (m_v[i] && (rd_ch !== 8'(m_ch[i]) || rd_x !== 9'(m_x[i]) || rd_y !== 10'(m_y[i])))) begin
          errors++; $display("FAIL rand_slot c=%0d i=%0d got v=%b ch=%0d x=%0d y=%0d want %b/%0d/%0d/%0d",
                             c, i, rd_valid, rd_ch, rd_x, rd_y, m_v[i], m_ch[i], m_x[i], m_y[i]); end
      end
    end
  endtask

  initial begin
    #1;
    model_reset();
    test_reset();
    test_spawn_advance();
    test_full_drop();
    test_hit();
    test_miss_nohit();
    test_commit_vs_frame();
    test_case_fold();
    test_reset_midscan();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end
endmodule
